// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one external half-precision adder between two clients.
// Optional FP_ARB_SUB_EN adds per-request subtract (sign-flip of operand b).
module fp_add_arbiter #(
  parameter int ADDER_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
`ifdef FP_ARB_SUB_EN
  input  logic        req0_sub,
`endif
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_sum,
  output logic        rsp0_ovf,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
`ifdef FP_ARB_SUB_EN
  input  logic        req1_sub,
`endif
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_sum,
  output logic        rsp1_ovf,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  input  logic        add_ovf,
  output logic        busy,
  output logic        ovf_sticky,
  input  logic        ovf_clr
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] CNT0 = 4'(ADDER_LAT - 1);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        gid_q, gid_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] add_a_q, add_a_d;
  logic [15:0] add_b_q, add_b_d;
  logic [15:0] sum0_q, sum0_d;
  logic [15:0] sum1_q, sum1_d;
  logic        ovf0_q, ovf0_d;
  logic        ovf1_q, ovf1_d;
  logic        stk_q, stk_d;
  logic        win1, any_v, sub_w, rsp_hs;
  logic [15:0] win_b;

  assign win1  = req1_valid & (~req0_valid | prio_q);
  assign any_v = req0_valid | req1_valid;
  assign win_b = win1 ? req1_b : req0_b;

`ifdef FP_ARB_SUB_EN
  assign sub_w = win1 ? req1_sub : req0_sub;
`else
  assign sub_w = 1'b0;
`endif

  assign rsp_hs = gid_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gid_d      = gid_q;
    cnt_d      = cnt_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    sum0_d     = sum0_q;
    sum1_d     = sum1_q;
    ovf0_d     = ovf0_q;
    ovf1_d     = ovf1_q;
    stk_d      = stk_q & ~ovf_clr;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_v) begin
          req0_ready = ~win1;
          req1_ready = win1;
          add_a_d    = win1 ? req1_a : req0_a;
          add_b_d    = {win_b[15] ^ sub_w, win_b[14:0]};
          gid_d      = win1;
          cnt_d      = CNT0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (gid_q) begin
            sum1_d = add_sum;
            ovf1_d = add_ovf;
          end else begin
            sum0_d = add_sum;
            ovf0_d = add_ovf;
          end
          // a new overflow outranks a same-cycle clear
          if (add_ovf) stk_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          prio_d  = ~gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      cnt_q   <= 4'd0;
      add_a_q <= 16'h0000;
      add_b_q <= 16'h0000;
      sum0_q  <= 16'h0000;
      sum1_q  <= 16'h0000;
      ovf0_q  <= 1'b0;
      ovf1_q  <= 1'b0;
      stk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      sum0_q  <= sum0_d;
      sum1_q  <= sum1_d;
      ovf0_q  <= ovf0_d;
      ovf1_q  <= ovf1_d;
      stk_q   <= stk_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign rsp0_sum   = sum0_q;
  assign rsp1_sum   = sum1_q;
  assign rsp0_ovf   = ovf0_q;
  assign rsp1_ovf   = ovf1_q;
  assign rsp0_valid = (state_q == RESP) & ~gid_q;
  assign rsp1_valid = (state_q == RESP) & gid_q;
  assign busy       = (state_q != IDLE);
  assign ovf_sticky = stk_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench: one arbiter at ADDER_LAT=1 and one at ADDER_LAT=4,
// each fed by a bench-controlled adder result.
module tb_fp_add_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---- DUT with ADDER_LAT=1
  logic        rst_n;
  logic        r0v, r1v, s0r, s1r, clr, ovf_m;
  logic        r0sub, r1sub;
  logic [15:0] r0a, r0b, r1a, r1b, sum_m;
  logic        r0rdy, r1rdy, v0, v1, o0, o1, bsy, stk;
  logic [15:0] sm0, sm1, aa, ab;

  fp_add_arbiter #(.ADDER_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b),
`ifdef FP_ARB_SUB_EN
    .req0_sub(r0sub),
`endif
    .rsp0_valid(v0), .rsp0_ready(s0r), .rsp0_sum(sm0), .rsp0_ovf(o0),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b),
`ifdef FP_ARB_SUB_EN
    .req1_sub(r1sub),
`endif
    .rsp1_valid(v1), .rsp1_ready(s1r), .rsp1_sum(sm1), .rsp1_ovf(o1),
    .add_a(aa), .add_b(ab), .add_sum(sum_m), .add_ovf(ovf_m),
    .busy(bsy), .ovf_sticky(stk), .ovf_clr(clr)
  );

  // ---- DUT with ADDER_LAT=4
  logic        rst4_n;
  logic        q0v, q1v, t0r, t1r, ovf4;
  logic [15:0] q0a, q0b, q1a, q1b, sum4;
  logic        q0rdy, q1rdy, w0, w1, p0, p1, bsy4, stk4;
  logic [15:0] tm0, tm1, ba, bb;

  fp_add_arbiter #(.ADDER_LAT(4)) u4 (
    .clk(clk), .rst_n(rst4_n),
    .req0_valid(q0v), .req0_ready(q0rdy), .req0_a(q0a), .req0_b(q0b),
`ifdef FP_ARB_SUB_EN
    .req0_sub(1'b0),
`endif
    .rsp0_valid(w0), .rsp0_ready(t0r), .rsp0_sum(tm0), .rsp0_ovf(p0),
    .req1_valid(q1v), .req1_ready(q1rdy), .req1_a(q1a), .req1_b(q1b),
`ifdef FP_ARB_SUB_EN
    .req1_sub(1'b0),
`endif
    .rsp1_valid(w1), .rsp1_ready(t1r), .rsp1_sum(tm1), .rsp1_ovf(p1),
    .add_a(ba), .add_b(bb), .add_sum(sum4), .add_ovf(ovf4),
    .busy(bsy4), .ovf_sticky(stk4), .ovf_clr(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_b;
  int          g;

  initial begin
    rst_n = 0; rst4_n = 0;
    r0v = 0; r1v = 0; s0r = 0; s1r = 0; clr = 0; ovf_m = 0;
    r0sub = 0; r1sub = 0;
    r0a = 0; r0b = 0; r1a = 0; r1b = 0; sum_m = 0;
    q0v = 0; q1v = 0; t0r = 0; t1r = 0; ovf4 = 0;
    q0a = 0; q0b = 0; q1a = 0; q1b = 0; sum4 = 0;
    tick(); tick();
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_add_a", 32'(aa), 0);
    chk("rst_add_b", 32'(ab), 0);
    chk("rst_v0", 32'(v0), 0);
    chk("rst_v1", 32'(v1), 0);
    chk("rst_sum0", 32'(sm0), 0);
    chk("rst_stk", 32'(stk), 0);
    rst_n = 1; rst4_n = 1;

    // single request from client 0
    r0v = 1; r0a = 16'h3C00; r0b = 16'h4000; sum_m = 16'h4200;
    #1;
    chk("t1_rdy0", 32'(r0rdy), 1);
    chk("t1_rdy1", 32'(r1rdy), 0);
    tick();
    r0v = 0;
    chk("t1_add_a", 32'(aa), 32'h3C00);
    chk("t1_add_b", 32'(ab), 32'h4000);
    chk("t1_busy", 32'(bsy), 1);
    chk("t1_v0_early", 32'(v0), 0);
    tick();
    chk("t1_v0", 32'(v0), 1);
    chk("t1_sum0", 32'(sm0), 32'h4200);
    chk("t1_ovf0", 32'(o0), 0);
    chk("t1_v1", 32'(v1), 0);
    s0r = 1;
    tick();
    s0r = 0;
    chk("t1_v0_drop", 32'(v0), 0);
    chk("t1_idle", 32'(bsy), 0);

    // both valid from reset: grants alternate 0,1,0,1
    rst_n = 0; tick(); rst_n = 1;
    r0v = 1; r1v = 1; s0r = 1; s1r = 1;
    r0a = 16'h0001; r0b = 16'h0002; r1a = 16'h0010; r1b = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      sum_m = 16'h1000 + 16'(i);
      #1;
      chk($sformatf("rr%0d_rdy0", i), 32'(r0rdy), 32'(g == 0));
      chk($sformatf("rr%0d_rdy1", i), 32'(r1rdy), 32'(g == 1));
      tick();
      chk($sformatf("rr%0d_add_a", i), 32'(aa), (g == 1) ? 32'h10 : 32'h1);
      tick();
      chk($sformatf("rr%0d_v0", i), 32'(v0), 32'(g == 0));
      chk($sformatf("rr%0d_v1", i), 32'(v1), 32'(g == 1));
      chk($sformatf("rr%0d_sum", i), (g == 1) ? 32'(sm1) : 32'(sm0),
          32'h1000 + 32'(i));
      tick();
    end
    r0v = 0; r1v = 0; s0r = 0; s1r = 0;

    // response stall: payload held, other client blocked
    r0v = 1; r1v = 1; sum_m = 16'h5555;
    tick();
    r0v = 0;
    tick();
    sum_m = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("st%0d_v0", i), 32'(v0), 1);
      chk($sformatf("st%0d_sum0", i), 32'(sm0), 32'h5555);
      chk($sformatf("st%0d_busy", i), 32'(bsy), 1);
      chk($sformatf("st%0d_rdy1", i), 32'(r1rdy), 0);
      tick();
    end
    s0r = 1;
    tick();
    s0r = 0;
    #1;
    chk("st_rdy1_after", 32'(r1rdy), 1);

    // overflow capture for client 1
    tick();
    r1v = 0; sum_m = 16'h7C00; ovf_m = 1;
    tick();
    chk("ov_v1", 32'(v1), 1);
    chk("ov_ovf1", 32'(o1), 1);
    chk("ov_sum1", 32'(sm1), 32'h7C00);
    chk("ov_stk", 32'(stk), 1);
    s1r = 1; ovf_m = 0;
    tick();
    s1r = 0;

    // clear together with a new overflow: set wins
    r0v = 1; r0a = 16'h7800; r0b = 16'h7800;
    tick();
    r0v = 0; ovf_m = 1; clr = 1;
    tick();
    clr = 0; ovf_m = 0;
    chk("oc_ovf0", 32'(o0), 1);
    chk("oc_stk", 32'(stk), 1);
    s0r = 1;
    tick();
    s0r = 0;
    clr = 1;
    tick();
    clr = 0;
    chk("oc_cleared", 32'(stk), 0);

    // client 1 with sub request (pointer now favours client 1)
    r1v = 1; r1a = 16'h3C00; r1b = 16'h4000; r1sub = 1;
`ifdef FP_ARB_SUB_EN
    exp_b = 16'hC000;
`else
    exp_b = 16'h4000;
`endif
    #1;
    chk("sub_rdy1", 32'(r1rdy), 1);
    tick();
    r1v = 0; r1sub = 0;
    chk("sub_add_b", 32'(ab), 32'(exp_b));
    chk("sub_add_a", 32'(aa), 32'h3C00);
    tick();
    s1r = 1;
    tick();
    s1r = 0;

    // ADDER_LAT=4 timing
    q0v = 1; q0a = 16'h1111; q0b = 16'h2222; sum4 = 16'h3333;
    #1;
    chk("l4_rdy0", 32'(q0rdy), 1);
    tick();
    q0v = 0;
    chk("l4_add_a", 32'(ba), 32'h1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l4_wait%0d_v0", i), 32'(w0), 0);
      chk($sformatf("l4_wait%0d_busy", i), 32'(bsy4), 1);
    end
    tick();
    chk("l4_v0", 32'(w0), 1);
    chk("l4_sum0", 32'(tm0), 32'h3333);
    t0r = 1;
    tick();
    t0r = 0;

    // reset while an operation is in WAIT
    q1v = 1; q1a = 16'h4444; q1b = 16'h5555;
    tick();
    q1v = 0;
    chk("l4r_add_a", 32'(ba), 32'h4444);
    tick();
    rst4_n = 0;
    tick();
    rst4_n = 1;
    chk("l4r_add_a0", 32'(ba), 0);
    chk("l4r_add_b0", 32'(bb), 0);
    chk("l4r_busy", 32'(bsy4), 0);
    chk("l4r_sum0", 32'(tm0), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("l4r%0d_v1", i), 32'(w1), 0);
      chk($sformatf("l4r%0d_busy", i), 32'(bsy4), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
